// File: rtl/sync_bram_pkg.sv
// Shared constants and elaboration helpers for the sync_bram_pipe RAM family.
package sync_bram_pkg;

  // Read-during-write selection for a same-address collision.
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // Deepest read pipeline supported (stage 1 plus two trailing stages).
  localparam int MAX_RD_LATENCY = 3;

  // Address width for a given depth; never below 1 so a 1-word RAM still has a port.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(value)) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Width of the byte-enable port: one lane per byte, or a single unused bit.
  function automatic int nbytes(input int dwidth, input int byte_wr);
    return (byte_wr != 0) ? (dwidth / 8) : 1;
  endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// Trailing read-return stages: shifts a valid bit and its payload one stage per cycle.
module bram_rd_pipe #(
  parameter int DATA_W = 34,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_vld,
  input  logic [DATA_W-1:0] load_dat,
  output logic              pipe_vld,
  output logic [DATA_W-1:0] pipe_dat
);

  if (STAGES < 1) begin : g_chk_stages
    $error("bram_rd_pipe needs at least one stage");
  end

  logic              vld_p [STAGES];
  logic [DATA_W-1:0] dat_p [STAGES];

  // Valid always shifts; each payload stage loads only when its incoming valid is set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        vld_p[i] <= 1'b0;
        dat_p[i] <= '0;
      end
    end else begin
      vld_p[0] <= load_vld;
      if (load_vld) dat_p[0] <= load_dat;
      for (int i = 1; i < STAGES; i++) begin
        vld_p[i] <= vld_p[i-1];
        if (vld_p[i-1]) dat_p[i] <= dat_p[i-1];
      end
    end
  end

  assign pipe_vld = vld_p[STAGES-1];
  assign pipe_dat = dat_p[STAGES-1];

endmodule

// File: rtl/sync_bram_pipe.sv
// Single-clock simple dual-port RAM with byte enables, 1-3 cycle registered read,
// selectable read-during-write behaviour, and collision / out-of-range flags.
module sync_bram_pipe
  import sync_bram_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DWIDTH     = 32,
  parameter int BYTE_WR    = 1,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = RDW_OLD,
  localparam int AWIDTH    = clog2(DEPTH),
  localparam int NBYTES    = nbytes(DWIDTH, BYTE_WR)
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              wen,
  input  logic [NBYTES-1:0] wbe,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              ren,
  input  logic [AWIDTH-1:0] raddr,
  output logic              rdv,
  output logic [DWIDTH-1:0] rdata,
  output logic              rd_collide,
  output logic              rd_oor
);

  if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_chk_lat
    $error("sync_bram_pipe: RD_LATENCY must be 1..3");
  end
  if (BYTE_WR != 0 && (DWIDTH % 8) != 0) begin : g_chk_width
    $error("sync_bram_pipe: DWIDTH must be a multiple of 8 with byte writes");
  end
  if (DEPTH < 1) begin : g_chk_depth
    $error("sync_bram_pipe: DEPTH must be at least 1");
  end

  localparam int BUS_W = DWIDTH + 2;
  // One extra bit so DEPTH == 2**AWIDTH still compares correctly.
  localparam logic [AWIDTH:0] DEPTH_LIM = (AWIDTH + 1)'(DEPTH);

  // Overlay enabled bytes of new_w onto old_w; whole-word replace without byte writes.
  function automatic logic [DWIDTH-1:0] merge_bytes(input logic [DWIDTH-1:0] old_w,
                                                    input logic [DWIDTH-1:0] new_w,
                                                    input logic [NBYTES-1:0] be);
    logic [DWIDTH-1:0] r;
    r = (BYTE_WR != 0) ? old_w : new_w;
    for (int i = 0; i < ((BYTE_WR != 0) ? NBYTES : 0); i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  logic [DWIDTH-1:0] mem [DEPTH];

  logic              wr_in_range;
  logic              rd_in_range;
  logic              collide;
  logic [DWIDTH-1:0] mem_word;
  logic [DWIDTH-1:0] rd_word;

  assign wr_in_range = ({1'b0, waddr} < DEPTH_LIM);
  assign rd_in_range = ({1'b0, raddr} < DEPTH_LIM);
  assign collide     = wen && ren && wr_in_range && (waddr == raddr);
  assign mem_word    = rd_in_range ? mem[raddr] : '0;

  // Pick the word stage 1 captures: old array contents, or the write-first bypass.
  always_comb begin
    rd_word = mem_word;
    if (RDW_MODE == RDW_NEW && collide) rd_word = merge_bytes(mem_word, wdata, wbe);
  end

  // Array write; contents survive reset and writes are ignored while reset is held.
  always_ff @(posedge clk) begin
    if (wen && !arst && wr_in_range) mem[waddr] <= merge_bytes(mem[waddr], wdata, wbe);
  end

  // ---- stage 1: array read plus flags ----
  logic             rd_vld_p0;
  logic [BUS_W-1:0] rd_bus_p0;

  // Stage 1 register: valid follows ren, payload loads only on a read.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rd_vld_p0 <= 1'b0;
      rd_bus_p0 <= '0;
    end else begin
      rd_vld_p0 <= ren;
      if (ren) rd_bus_p0 <= {!rd_in_range, collide, rd_word};
    end
  end

  // ---- stages 2..RD_LATENCY: return pipeline ----
  logic             out_vld;
  logic [BUS_W-1:0] out_bus;

  if (RD_LATENCY > 1) begin : g_pipe
    bram_rd_pipe #(
      .DATA_W (BUS_W),
      .STAGES (RD_LATENCY - 1)
    ) u_rd_pipe (
      .clk      (clk),
      .rst      (arst),
      .load_vld (rd_vld_p0),
      .load_dat (rd_bus_p0),
      .pipe_vld (out_vld),
      .pipe_dat (out_bus)
    );
  end else begin : g_direct
    assign out_vld = rd_vld_p0;
    assign out_bus = rd_bus_p0;
  end

  assign rdv        = out_vld;
  assign rd_oor     = out_bus[BUS_W-1];
  assign rd_collide = out_bus[BUS_W-2];
  assign rdata      = out_bus[DWIDTH-1:0];

endmodule

// File: tb/tb_sync_bram_pipe.sv
// Directed bench: three RAM configurations share one stimulus stream.
//   a: DEPTH 16, byte writes, latency 1, old-data on collision
//   b: DEPTH 16, word writes, latency 1, old-data on collision
//   c: DEPTH 12, byte writes, latency 3, new-data on collision
module tb_sync_bram_pipe;

  logic        clk = 1'b0;
  logic        arst = 1'b0;
  logic        wen = 1'b0;
  logic [3:0]  wbe = 4'h0;
  logic [3:0]  waddr = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic        ren = 1'b0;
  logic [3:0]  raddr = 4'h0;

  logic        rdv_a, col_a, oor_a;
  logic [31:0] rdata_a;
  logic        rdv_b, col_b, oor_b;
  logic [31:0] rdata_b;
  logic        rdv_c, col_c, oor_c;
  logic [31:0] rdata_c;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sync_bram_pipe #(.DEPTH(16), .DWIDTH(32), .BYTE_WR(1), .RD_LATENCY(1), .RDW_MODE(0)) u_a (
    .clk(clk), .arst(arst), .wen(wen), .wbe(wbe), .waddr(waddr), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rdv(rdv_a), .rdata(rdata_a), .rd_collide(col_a), .rd_oor(oor_a));

  sync_bram_pipe #(.DEPTH(16), .DWIDTH(32), .BYTE_WR(0), .RD_LATENCY(1), .RDW_MODE(0)) u_b (
    .clk(clk), .arst(arst), .wen(wen), .wbe(wbe[0]), .waddr(waddr), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rdv(rdv_b), .rdata(rdata_b), .rd_collide(col_b), .rd_oor(oor_b));

  sync_bram_pipe #(.DEPTH(12), .DWIDTH(32), .BYTE_WR(1), .RD_LATENCY(3), .RDW_MODE(1)) u_c (
    .clk(clk), .arst(arst), .wen(wen), .wbe(wbe), .waddr(waddr), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rdv(rdv_c), .rdata(rdata_c), .rd_collide(col_c), .rd_oor(oor_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic idle();
    wen = 1'b0;
    ren = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    wen = 1'b1; waddr = a; wdata = d; wbe = be; ren = 1'b0;
    @(negedge clk);
    wen = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    ren = 1'b1; raddr = a; wen = 1'b0;
    @(negedge clk);
    ren = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state
    #1 arst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_rdv_a", 32'(rdv_a), 32'd0);
    check("rst_rdata_a", rdata_a, 32'd0);
    check("rst_rdv_c", 32'(rdv_c), 32'd0);
    check("rst_flags_c", {30'd0, oor_c, col_c}, 32'd0);
    arst = 1'b0;
    idle();

    // basic read, latency 1 on a and latency 3 on c
    wr(4'd3, 32'hDEADBEEF, 4'hF);
    rd(4'd3);
    check("basic_rdv_a", 32'(rdv_a), 32'd1);
    check("basic_rdata_a", rdata_a, 32'hDEADBEEF);
    check("basic_flags_a", {30'd0, oor_a, col_a}, 32'd0);
    check("lat3_early_c", 32'(rdv_c), 32'd0);
    idle();
    check("basic_pulse_a", 32'(rdv_a), 32'd0);
    check("basic_hold_a", rdata_a, 32'hDEADBEEF);
    check("lat3_early2_c", 32'(rdv_c), 32'd0);
    idle();
    check("lat3_rdv_c", 32'(rdv_c), 32'd1);
    check("lat3_rdata_c", rdata_c, 32'hDEADBEEF);
    idle();
    check("lat3_pulse_c", 32'(rdv_c), 32'd0);

    // byte enables
    wr(4'd5, 32'h11223344, 4'hF);
    wr(4'd5, 32'hAABBCCDD, 4'b0101);
    rd(4'd5);
    check("be_rdata_a", rdata_a, 32'h11BB33DD);
    check("be_word_b", rdata_b, 32'hAABBCCDD);
    idle();
    idle();
    check("be_rdata_c", rdata_c, 32'h11BB33DD);
    idle();

    // back-to-back reads through the 3-stage pipe
    for (int i = 0; i < 8; i++) wr(4'(i), 32'(i * 16), 4'hF);
    for (int i = 0; i < 10; i++) begin
      ren = (i < 8);
      raddr = 4'(i);
      @(negedge clk);
      if (i < 8) check($sformatf("thr_a_%0d", i), rdata_a, 32'(i * 16));
      check($sformatf("thr_vld_c_%0d", i), 32'(rdv_c), (i >= 2) ? 32'd1 : 32'd0);
      if (i >= 2) check($sformatf("thr_dat_c_%0d", i), rdata_c, 32'((i - 2) * 16));
    end
    ren = 1'b0;
    idle();
    check("thr_end_c", 32'(rdv_c), 32'd0);

    // same-address read during write
    wr(4'd2, 32'h000000FF, 4'hF);
    wen = 1'b1; waddr = 4'd2; wdata = 32'h12345678; wbe = 4'b1100;
    ren = 1'b1; raddr = 4'd2;
    @(negedge clk);
    wen = 1'b0; ren = 1'b0;
    check("col_old_a", rdata_a, 32'h000000FF);
    check("col_flag_a", 32'(col_a), 32'd1);
    check("col_old_b", rdata_b, 32'h000000FF);
    idle();
    idle();
    check("col_new_c", rdata_c, 32'h123400FF);
    check("col_flag_c", 32'(col_c), 32'd1);
    rd(4'd2);
    check("col_after_a", rdata_a, 32'h123400FF);
    check("col_after_flag_a", 32'(col_a), 32'd0);
    check("col_after_b", rdata_b, 32'h12345678);
    idle();
    idle();
    check("col_after_c", rdata_c, 32'h123400FF);

    // non-power-of-two depth on c
    wr(4'd1, 32'hCAFE0001, 4'hF);
    wr(4'd13, 32'hBAD00BAD, 4'hF);
    rd(4'd1);
    rd(4'd13);
    check("oor_ok_a", rdata_a, 32'hBAD00BAD);
    check("oor_none_a", 32'(oor_a), 32'd0);
    idle();
    check("oor_keep_c", rdata_c, 32'hCAFE0001);
    check("oor_keep_flag_c", 32'(oor_c), 32'd0);
    idle();
    check("oor_rdv_c", 32'(rdv_c), 32'd1);
    check("oor_rdata_c", rdata_c, 32'd0);
    check("oor_flag_c", 32'(oor_c), 32'd1);
    idle();
    idle();

    // reset with reads in flight
    rd(4'd4);
    rd(4'd6);
    arst = 1'b1;
    #1;
    check("mid_rst_rdv_a", 32'(rdv_a), 32'd0);
    check("mid_rst_rdata_a", rdata_a, 32'd0);
    check("mid_rst_rdv_c", 32'(rdv_c), 32'd0);
    check("mid_rst_rdata_c", rdata_c, 32'd0);
    wen = 1'b1; waddr = 4'd4; wdata = 32'hFFFFFFFF; wbe = 4'hF;
    ren = 1'b1; raddr = 4'd4;
    @(negedge clk);
    wen = 1'b0; ren = 1'b0;
    @(negedge clk);
    arst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle();
      check($sformatf("post_rst_rdv_c_%0d", i), 32'(rdv_c), 32'd0);
    end
    rd(4'd4);
    check("retain_a", rdata_a, 32'h00000040);
    idle();
    idle();
    check("retain_rdv_c", 32'(rdv_c), 32'd1);
    check("retain_c", rdata_c, 32'h00000040);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
